// File: rtl/fc_result_streamer_if.sv
// ---------------------------------------------------------------------------
// Module  : fc_result_streamer_if
// Brief   : Element stream bus (valid/ready) leaving the FC result streamer.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface fc_result_streamer_if #(
  parameter int BIT = 8,
  parameter int IW  = 8
);
  logic           out_valid;
  logic           out_ready;
  logic [BIT-1:0] out_data;
  logic [IW-1:0]  out_index;
  logic           out_last;

  // Streamer side: drives the beat, samples ready
  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  // Next-layer side: consumes the beat, drives ready
  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

`default_nettype wire

// File: rtl/fc_result_streamer.sv
// ---------------------------------------------------------------------------
// Module  : fc_result_streamer
// Brief   : Captures the packed FC ReLU result vector on the done edge, streams
//           it one element per beat and tracks argmax / max_value on the fly.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module fc_result_streamer #(
  parameter int BIT = 8,
  parameter int N   = 128,
  parameter int IW  = 8
) (
  input  logic                 clk,
  input  logic                 iRst_n,
  input  logic                 ena,
  input  logic                 fc_done,
  input  logic                 fc_overflow,
  input  logic [N*BIT-1:0]     data_from_fc,
  fc_result_streamer_if.master strm,
  output logic [IW-1:0]        argmax,
  output logic [BIT-1:0]       max_value,
  output logic                 result_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam logic [1:0]    c_IDLE     = 2'd0;
  localparam logic [1:0]    c_STREAM   = 2'd1;
  localparam logic [1:0]    c_DONE     = 2'd2;
  localparam logic [IW-1:0] c_LAST_IDX = IW'(N - 1);
  localparam int            c_BW       = $clog2(N * BIT);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             r_done_d;
  logic [N*BIT-1:0] r_cap;
  logic [IW-1:0]    r_index;
  logic [IW-1:0]    r_argmax;
  logic [BIT-1:0]   r_max;
  logic             r_result_valid;
  logic             r_overflow;
  logic             r_busy;

  logic             w_start;
  logic             w_load;
  logic             w_valid;
  logic             w_last;
  logic             w_at_last;
  logic             w_xfer;
  logic [c_BW-1:0]  w_base;
  logic [BIT-1:0]   w_cur;

  // Rising edge of the level done; a run in progress never re-captures.
  assign w_start   = fc_done & ~r_done_d;
  assign w_load    = w_start & (r_state != c_STREAM);
  assign w_at_last = (r_index == c_LAST_IDX);
  assign w_xfer    = w_valid & strm.out_ready;
  assign w_base    = c_BW'(r_index) * c_BW'(BIT);
  assign w_cur     = r_cap[w_base +: BIT];

  // State register; ena low freezes the FSM.
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      r_state <= c_IDLE;
    end else if (ena) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: idle/done wait for a start edge, stream ends on the last accepted beat.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE, c_DONE: if (w_start) w_state_nxt = c_STREAM;
      c_STREAM:       if (w_xfer && w_at_last) w_state_nxt = c_DONE;
      default:        w_state_nxt = c_IDLE;
    endcase
  end

  // Beat qualifiers; valid is masked by ena so a frozen block never transfers.
  always_comb begin
    w_valid = 1'b0;
    w_last  = 1'b0;
    if (r_state == c_STREAM) begin
      w_valid = ena;
      w_last  = w_at_last;
    end
  end

  // Capture, index walk and running argmax (strict > keeps the lowest index on ties).
  always_ff @(posedge clk) begin
    if (!iRst_n) begin
      r_done_d       <= 1'b0;
      r_cap          <= '0;
      r_index        <= '0;
      r_argmax       <= '0;
      r_max          <= '0;
      r_result_valid <= 1'b0;
      r_overflow     <= 1'b0;
      r_busy         <= 1'b0;
    end else if (ena) begin
      r_done_d <= fc_done;
      if (w_load) begin
        r_cap          <= data_from_fc;
        r_overflow     <= fc_overflow;
        r_index        <= '0;
        r_argmax       <= '0;
        r_max          <= '0;
        r_result_valid <= 1'b0;
        r_busy         <= 1'b1;
      end else if (w_xfer) begin
        if (w_cur > r_max) begin
          r_argmax <= r_index;
          r_max    <= w_cur;
        end
        if (w_at_last) begin
          r_result_valid <= 1'b1;
          r_busy         <= 1'b0;
        end else begin
          r_index <= r_index + 1'b1;
        end
      end
    end
  end

  assign strm.out_valid = w_valid;
  assign strm.out_last  = w_last;
  assign strm.out_data  = w_cur;
  assign strm.out_index = r_index;
  assign argmax         = r_argmax;
  assign max_value      = r_max;
  assign result_valid   = r_result_valid;
  assign overflow       = r_overflow;
  assign busy           = r_busy;

endmodule

`default_nettype wire
